// File: rtl/symbol_tx_pkg.sv
// rtl/symbol_tx_pkg.sv - shared widths and helpers for the DAU symbol transmit path

`ifndef DAU_SYM_WIDTH
`define DAU_SYM_WIDTH 4
`endif

package symbol_tx_pkg;

  // Symbol width as defined for the DAU symbol interface.
  localparam int SYM_W = `DAU_SYM_WIDTH;

  // Pointer/count width: address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic synchronous FIFO with wrap-bit pointers and registered flags

module sync_fifo
  import symbol_tx_pkg::*;
#(
  parameter int WIDTH = SYM_W,
  parameter int DEPTH = 8,
  parameter int PEEK  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         peek_data,
  output logic [ptr_w(DEPTH)-1:0]  count,
  output logic                     full,
  output logic                     not_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = ptr_w(DEPTH);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] PEEK_OFS = CW'(PEEK);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;
  logic [CW-1:0]    peek_ptr;
  logic [CW-1:0]    count_d;
  logic             push_ok;
  logic             pop_ok;

  // Guard against overrun/underrun even if the caller does not.
  assign push_ok   = push && !full;
  assign pop_ok    = pop && not_empty;
  assign peek_ptr  = rd_ptr + PEEK_OFS;
  assign peek_data = mem[peek_ptr[AW-1:0]];

  // Next occupancy from this cycle's accepted push/pop.
  always_comb begin
    count_d = count;
    if (push_ok && !pop_ok) begin
      count_d = count + ONE;
    end else if (pop_ok && !push_ok) begin
      count_d = count - ONE;
    end
  end

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointers wrap modulo 2*DEPTH; count and flags are registered from count_d.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      not_empty <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ONE;
      end
      count     <= count_d;
      full      <= (count_d == FULL_CNT);
      not_empty <= (count_d != '0);
    end
  end

endmodule

// File: rtl/symbol_tx.sv
// rtl/symbol_tx.sv - queued symbol source for the DAU input; optional overflow flag via SYMBOL_TX_OVF_EN

module symbol_tx
  import symbol_tx_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int SYM_WIDTH = `DAU_SYM_WIDTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wr,
  input  logic [SYM_WIDTH-1:0]      i_wr_symbol,
  input  logic                      i_ready,
`ifdef SYMBOL_TX_OVF_EN
  output logic                      o_ovf,
  input  logic                      i_clr_ovf,
`endif
  output logic                      o_full,
  output logic [ptr_w(DEPTH)-1:0]   o_count,
  output logic                      o_valid,
  output logic [SYM_WIDTH-1:0]      o_symbol
);

  localparam int CW = ptr_w(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic                 push;
  logic                 pop;
  logic [SYM_WIDTH-1:0] next_head;
  logic [SYM_WIDTH-1:0] head_d;

  // Both strobes depend only on registered flags, so a write while full is
  // dropped even when a pop frees a slot in the same cycle.
  assign push = i_wr && !o_full;
  assign pop  = o_valid && i_ready;

  // The FIFO holds every queued symbol, head included; the peek port looks one
  // entry past the head so the output stage can reload with no idle cycle.
  sync_fifo #(
    .WIDTH (SYM_WIDTH),
    .DEPTH (DEPTH),
    .PEEK  (1)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data (i_wr_symbol),
    .pop       (pop),
    .peek_data (next_head),
    .count     (o_count),
    .full      (o_full),
    .not_empty (o_valid)
  );

  // Choose what the output stage shows after this edge.
  always_comb begin
    head_d = o_symbol;
    if (pop && (o_count > ONE)) begin
      head_d = next_head;
    end else if (push && ((o_count == '0) || (pop && (o_count == ONE)))) begin
      head_d = i_wr_symbol;
    end
  end

  // Registered output stage; holds while stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_symbol <= '0;
    end else begin
      o_symbol <= head_d;
    end
  end

`ifdef SYMBOL_TX_OVF_EN
  // Sticky overflow: a dropped write sets it and takes priority over clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_ovf <= 1'b0;
    end else if (i_wr && o_full) begin
      o_ovf <= 1'b1;
    end else if (i_clr_ovf) begin
      o_ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_symbol_tx.sv
// tb/tb_symbol_tx.sv - scoreboard bench for symbol_tx with a queue-based reference model

`ifndef DAU_SYM_WIDTH
`define DAU_SYM_WIDTH 4
`endif

module tb_symbol_tx;

  localparam int DEPTH = 8;
  localparam int W     = `DAU_SYM_WIDTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_wr;
  logic [W-1:0]  i_wr_symbol;
  logic          i_ready;
  logic          i_clr_ovf;
  logic          o_full;
  logic [CW-1:0] o_count;
  logic          o_valid;
  logic [W-1:0]  o_symbol;
`ifdef SYMBOL_TX_OVF_EN
  logic          o_ovf;
`endif

  symbol_tx #(.DEPTH(DEPTH), .SYM_WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_wr        (i_wr),
    .i_wr_symbol (i_wr_symbol),
    .i_ready     (i_ready),
`ifdef SYMBOL_TX_OVF_EN
    .o_ovf       (o_ovf),
    .i_clr_ovf   (i_clr_ovf),
`endif
    .o_full      (o_full),
    .o_count     (o_count),
    .o_valid     (o_valid),
    .o_symbol    (o_symbol)
  );

  always #5 i_clk = ~i_clk;

  logic [W-1:0] exp_q[$];
  int           exp_count = 0;
  logic         exp_ovf   = 1'b0;
  int           total     = 0;
  int           bad       = 0;
  bit           mon_en    = 1'b0;
  int           written;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares state and pops the scoreboard on every transfer.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge i_clk);
      if (mon_en) begin
        check("count", int'(o_count), exp_count);
        check("full", int'(o_full), int'(exp_count == DEPTH));
        check("valid", int'(o_valid), int'(exp_count != 0));
`ifdef SYMBOL_TX_OVF_EN
        check("ovf", int'(o_ovf), int'(exp_ovf));
`endif
        if (i_rst_n && o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_empty: got symbol %0d expected no transfer at %0t", o_symbol, $time);
          end else begin
            e = exp_q.pop_front();
            check("symbol", int'(o_symbol), int'(e));
          end
        end
      end
    end
  end

  // One clock of stimulus; the model decides what the upcoming edge must do.
  task automatic cycle(input logic wr, input logic [W-1:0] sym, input logic rdy, input logic clr);
    logic acc, pp, nov;
    int   nc;
    i_wr        = wr;
    i_wr_symbol = sym;
    i_ready     = rdy;
    i_clr_ovf   = clr;
    acc = wr && (exp_count != DEPTH);
    pp  = rdy && (exp_count != 0);
    if (acc) exp_q.push_back(sym);
    nc  = exp_count + int'(acc) - int'(pp);
    nov = (wr && exp_count == DEPTH) ? 1'b1 : (clr ? 1'b0 : exp_ovf);
    @(posedge i_clk);
    exp_count = nc;
    exp_ovf   = nov;
    #1;
  endtask

  task automatic do_reset(input int n);
    i_rst_n     = 1'b0;
    i_wr        = 1'b1;
    i_wr_symbol = W'($urandom);
    i_ready     = 1'($urandom);
    i_clr_ovf   = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      exp_q.delete();
      exp_count = 0;
      exp_ovf   = 1'b0;
      #1;
      if (mon_en) check("reset_symbol", int'(o_symbol), 0);
    end
    i_rst_n = 1'b1;
    i_wr    = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_count != 0 && guard < 200) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
    if (exp_count != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got count %0d expected 0", exp_count);
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("drained", exp_q.size(), 0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_wr = 1'b0; i_wr_symbol = '0; i_ready = 1'b0; i_clr_ovf = 1'b0;
    do_reset(2);
    mon_en = 1'b1;
    do_reset(3);
    check("reset_count", int'(o_count), 0);

    // single symbol
    cycle(1'b1, W'(5), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // stall then burst
    cycle(1'b1, W'(3), 1'b0, 1'b0);
    cycle(1'b1, W'(1), 1'b0, 1'b0);
    cycle(1'b1, W'(4), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("stall_head", int'(o_symbol), 3);
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // full and overflow
    for (int k = 0; k < 9; k++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    drain();

    // full boundary: write dropped while popping, then write+pop at count 3
    for (int k = 0; k < 8; k++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
    cycle(1'b1, W'($urandom), 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    while (exp_count > 3) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, W'($urandom), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    drain();

    // single queued symbol replaced by a same-cycle write
    cycle(1'b1, W'(7), 1'b0, 1'b0);
    cycle(1'b1, W'(2), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    drain();

    // 20 symbols with random ready across pointer wrap
    written = 0;
    for (int k = 0; k < 400 && written < 20; k++) begin
      logic w;
      w = 1'($urandom);
      if (w && exp_count != DEPTH) written++;
      cycle(w, W'($urandom), 1'($urandom), 1'b0);
    end
    drain();

    // reset with 5 queued
    for (int k = 0; k < 5; k++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
    do_reset(2);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1, 1'b0);

    // random soak
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 15) == 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/symbol_tx.md
# symbol_tx

Transmit-side buffer for the DAU symbol input interface. Accepts symbols from an upstream source (keypad decoder, UART front end) at arbitrary times, queues them in a small FIFO, and presents them to the DAU's `i_valid`/`i_symbol` input. Transfers happen only while the DAU asserts `o_ready`, so bursts of keystrokes are not lost while an arithmetic operation is in progress.

## Interface
Parameters:
- `DEPTH`, 8: total symbol capacity; power of two, at least 2.
- `SYM_WIDTH`, `` `DAU_SYM_WIDTH ``: symbol width, taken from `dau_symbols.vh`.

Ports:
- `i_clk`, input, 1: clock; all logic is on the rising edge.
- `i_rst_n`, input, 1: reset. Synchronous, active-low.
- `i_wr`, input, 1: upstream write strobe, one symbol per cycle.
- `i_wr_symbol`, input, SYM_WIDTH: symbol to enqueue.
- `o_full`, output, 1: no free slot; a write in this cycle is dropped.
- `o_count`, output, $clog2(DEPTH)+1: occupancy, 0..DEPTH.
- `o_valid`, output, 1: connects to DAU `i_valid`.
- `o_symbol`, output, SYM_WIDTH: connects to DAU `i_symbol`.
- `i_ready`, input, 1: connects to DAU `o_ready`.
- `o_ovf`, output, 1: sticky overflow flag. Present only with `SYMBOL_TX_OVF_EN`.
- `i_clr_ovf`, input, 1: clears `o_ovf`. Present only with `SYMBOL_TX_OVF_EN`.

## Operation
- **Queue.** FIFO order is strict; no symbol is reordered or duplicated. The head symbol is held in a registered output stage that drives `o_symbol`. Storage counts toward `DEPTH`.
- **Transfer.**
  - A transfer (pop) occurs in any cycle where `o_valid && i_ready`.
  - After a pop, the next head loads into the output stage. If the queue still holds symbols, `o_valid` stays high on the following cycle (back-to-back issue).
- **Hold stability.** While `o_valid && !i_ready`, `o_symbol` and `o_valid` hold stable. `o_valid` is never retracted without a pop.
- **Write.** A write is accepted when `i_wr && !o_full`. `o_full` is computed from registered state only: a write while full is dropped, even if a pop happens in the same cycle.
- **Simultaneous write and pop when not full.** Both take effect; `o_count` is unchanged.
- **Simultaneous write and pop when exactly one symbol is queued.** The written symbol becomes the new head on the next cycle.
- **Count and flags.** `o_count` equals accepted writes minus pops. `o_full = (o_count == DEPTH)`. `o_valid = (o_count != 0)`.
- **Pointers.** Read and write pointers are $clog2(DEPTH)+1 bits, with the extra bit as a wrap bit. They wrap modulo 2·DEPTH; full/empty are unambiguous at wrap-around.
- **Reset behaviour.** Reset mid-operation discards all queued symbols; no partial transfer completes.

## Timing
- Reset values: `o_valid`=0, `o_symbol`=0, `o_full`=0, `o_count`=0, `o_ovf`=0.
- Write-to-valid latency into an empty queue: 1 cycle. A write at edge N gives `o_valid`=1 with that symbol after edge N.
- Pop-to-next-head latency: 0 idle cycles. The next symbol is presented immediately after the accepting edge.
- Throughput: 1 symbol per cycle in each direction.
- `o_full` and `o_count` update on the edge following the causing event.
- All outputs are registered; there are no combinational paths from `i_wr` or `i_ready` to any output.

## Configuration
- Macro: `SYMBOL_TX_OVF_EN`.
- **Defined:**
  - `o_ovf` is set on the edge after any dropped write (`i_wr && o_full`).
  - It stays set until `i_clr_ovf`=1 or reset.
  - If a set condition and `i_clr_ovf` occur in the same cycle, set wins.
- **Undefined:** ports `o_ovf`/`i_clr_ovf` and the flag register are absent. Dropped writes are silent; all other behaviour is identical.

## Structure
- Symbol width comes from `dau_symbols.vh` (`` `DAU_SYM_WIDTH ``). No new symbol encodings are added.
- Sub-module `sync_fifo`: parameterised storage, pointers and count, with no knowledge of symbols. It is reusable for the DAU output path.
- `symbol_tx` adds:
  - the registered output stage;
  - the valid/ready handshake;
  - the overflow option.

## Test plan
- **Reset:** hold `i_rst_n`=0 with `i_wr`=1 -> `o_valid`=0, `o_count`=0, `o_full`=0 throughout.
- **Single symbol:** write 0x5 into an empty queue with `i_ready`=1 -> `o_valid`=1 and `o_symbol`=0x5 one cycle later; popped on that cycle; `o_count` back to 0 the next cycle.
- **Stall:** `i_ready`=0, write 3,1,4 -> `o_symbol` holds 3 with `o_count`=3. Raise `i_ready` for 3 cycles -> 3,1,4 delivered on consecutive cycles, then `o_valid`=0.
- **Full and overflow** (DEPTH=8, `i_ready`=0): write 9 symbols -> `o_full`=1 after the 8th; the 9th is dropped. With `SYMBOL_TX_OVF_EN`, `o_ovf`=1 and stays set until `i_clr_ovf`. Draining returns exactly the first 8 in order.
- **Full-boundary same cycle:** when full, `i_wr` and pop in the same cycle -> write dropped, `o_count`=7. At count 3, write and pop together -> `o_count` stays 3.
- **Wrap and reset:** stream 20 symbols with random `i_ready` -> in-order delivery across pointer wrap. Assert reset with 5 queued -> the queue empties and none are delivered afterwards.
